// File: rtl/nios2_qsys_cpu_oci_pkg.sv
// rtl/nios2_qsys_cpu_oci_pkg.sv - shared constants, FSM state and frame type for the OCI DCT packer
package nios2_qsys_cpu_oci_pkg;
    localparam int DCT_CODE_W = 2;
    localparam int DCT_DEPTH  = 15;
    localparam int DCT_BUF_W  = DCT_CODE_W * DCT_DEPTH;

    typedef enum logic [1:0] {
        TE_IDLE,
        TE_DRAIN,
        TE_ENDING,
        TE_ENDED
    } test_end_state_t;

    typedef struct packed {
        logic [3:0]           count;
        logic [DCT_BUF_W-1:0] buffer;
    } dct_frame_t;
endpackage

// File: rtl/nios2_qsys_cpu_oci_dct_packer_if.sv
// rtl/nios2_qsys_cpu_oci_dct_packer_if.sv - valid/ready frame channel between packer and trace test bench stage
interface nios2_qsys_cpu_oci_dct_packer_if
    import nios2_qsys_cpu_oci_pkg::*;
#(
    parameter int FRAME_W = 4 + DCT_BUF_W
);
    logic               frame_valid;
    logic               frame_ready;
    logic [FRAME_W-1:0] frame_data;

    modport master (output frame_valid, output frame_data, input frame_ready);
    modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/nios2_qsys_cpu_oci_frame_slot.sv
// rtl/nios2_qsys_cpu_oci_frame_slot.sv - one-entry valid/ready holding register for completed frames
module nios2_qsys_cpu_oci_frame_slot #(
    parameter int W = 34
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data,
    output logic         free
);
    // A load while the current frame is being taken replaces it with no bubble.
    assign free = !valid || ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/nios2_qsys_cpu_oci_dct_packer.sv
// rtl/nios2_qsys_cpu_oci_dct_packer.sv - packs 2-bit DCT codes into frames and sequences end-of-test drain
module nios2_qsys_cpu_oci_dct_packer
    import nios2_qsys_cpu_oci_pkg::*;
#(
    parameter int  CODE_W = DCT_CODE_W,
    parameter int  DEPTH  = DCT_DEPTH,
    localparam int BUF_W  = CODE_W * DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dct_valid,
    input  logic [CODE_W-1:0] dct_code,
    input  logic              flush,
    input  logic              test_end_req,
    input  logic              overflow_clr,
    output logic [BUF_W-1:0]  dct_buffer,
    output logic [3:0]        dct_count,
    output logic              overflow,
    output logic              test_ending,
    output logic              test_has_ended,
    nios2_qsys_cpu_oci_dct_packer_if.master frm
);
    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    test_end_state_t  state, state_nxt;
    logic             flush_pend;
    logic             slot_free;
    logic             accept, drop, flush_eff, close, load;
    logic [BUF_W-1:0] new_buf;
    logic [3:0]       new_cnt;

    // Codes are only taken while idle; draining and ended phases ignore them silently.
    always_comb begin
        accept    = dct_valid && (state == TE_IDLE) && (dct_count != DEPTH_C) && !flush_pend;
        drop      = dct_valid && (state == TE_IDLE) && ((dct_count == DEPTH_C) || flush_pend);
        new_buf   = accept ? {dct_buffer[BUF_W-CODE_W-1:0], dct_code} : dct_buffer;
        new_cnt   = dct_count + {3'b000, accept};
        flush_eff = flush || flush_pend || (state == TE_DRAIN);
        close     = (new_cnt == DEPTH_C) || (flush_eff && (new_cnt != 4'd0));
        load      = close && slot_free;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dct_buffer <= '0;
            dct_count  <= 4'd0;
            flush_pend <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (load) begin
                dct_buffer <= '0;
                dct_count  <= 4'd0;
                flush_pend <= 1'b0;
            end else begin
                dct_buffer <= new_buf;
                dct_count  <= new_cnt;
                flush_pend <= flush_pend || (flush && (new_cnt != 4'd0));
            end
            overflow <= drop || (overflow && !overflow_clr);
        end
    end

    nios2_qsys_cpu_oci_frame_slot #(.W(4 + BUF_W)) u_slot (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .load_data ({new_cnt, new_buf}),
        .ready     (frm.frame_ready),
        .valid     (frm.frame_valid),
        .data      (frm.frame_data),
        .free      (slot_free)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= TE_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TE_IDLE:   if (test_end_req) state_nxt = TE_DRAIN;
            TE_DRAIN:  if ((dct_count == 4'd0) && !flush_pend && !frm.frame_valid) state_nxt = TE_ENDING;
            TE_ENDING: state_nxt = TE_ENDED;
            default:   state_nxt = TE_ENDED;
        endcase
    end

    always_comb begin
        test_ending    = (state == TE_ENDING);
        test_has_ended = (state == TE_ENDED);
    end
endmodule

// File: tb/tb_nios2_qsys_cpu_oci_dct_packer.sv
// tb/tb_nios2_qsys_cpu_oci_dct_packer.sv - self-checking bench for the OCI DCT packer
module tb_nios2_qsys_cpu_oci_dct_packer;
    import nios2_qsys_cpu_oci_pkg::*;

    logic        clk = 1'b0;
    logic        reset, dct_valid, flush, test_end_req, overflow_clr;
    logic [1:0]  dct_code;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        overflow, test_ending, test_has_ended;

    nios2_qsys_cpu_oci_dct_packer_if frm ();

    nios2_qsys_cpu_oci_dct_packer dut (
        .clk            (clk),
        .reset          (reset),
        .dct_valid      (dct_valid),
        .dct_code       (dct_code),
        .flush          (flush),
        .test_end_req   (test_end_req),
        .overflow_clr   (overflow_clr),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .overflow       (overflow),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .frm            (frm.master)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference model: codes of the open frame in arrival order, plus the held frame.
    int         q[$];
    bit         m_pend, m_hv, m_ovf;
    dct_frame_t m_hd;
    int         m_st;

    wire [71:0] dut_obs = {dct_buffer, dct_count, frm.frame_valid,
                           (frm.frame_valid ? frm.frame_data : 34'h0),
                           overflow, test_ending, test_has_ended};

    function automatic logic [29:0] pack(input int cq[$]);
        logic [29:0] b = '0;
        foreach (cq[i]) b = b * 4 + 30'(cq[i]);
        return b;
    endfunction

    task automatic model_update();
        int nst;
        bit free, dropped, flushing, ld;
        if (reset) begin
            q.delete();
            m_pend = 0; m_hv = 0; m_ovf = 0; m_hd = '0; m_st = 0;
            return;
        end
        nst = m_st;
        case (m_st)
            0: if (test_end_req) nst = 1;
            1: if (q.size() == 0 && !m_pend && !m_hv) nst = 2;
            default: nst = 3;
        endcase
        free    = !m_hv || frm.frame_ready;
        dropped = 0;
        if (dct_valid && m_st == 0) begin
            if (q.size() == 15 || m_pend) dropped = 1;
            else q.push_back(int'(dct_code));
        end
        flushing = flush || m_pend || (m_st == 1);
        ld = free && (q.size() == 15 || (flushing && q.size() > 0));
        if (m_hv && frm.frame_ready) m_hv = 0;
        if (ld) begin
            m_hd.count  = 4'(q.size());
            m_hd.buffer = pack(q);
            m_hv = 1;
            q.delete();
            m_pend = 0;
        end else if (flush && q.size() > 0) begin
            m_pend = 1;
        end
        if (dropped) m_ovf = 1;
        else if (overflow_clr) m_ovf = 0;
        m_st = nst;
    endtask

    task automatic step(input bit v, input bit [1:0] c, input bit f, input bit rq,
                        input bit clr, input bit rdy, input bit rst);
        dct_valid = v; dct_code = c; flush = f; test_end_req = rq;
        overflow_clr = clr; frm.frame_ready = rdy; reset = rst;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        step(0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (dut_obs !== 72'h0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", dut_obs);
        end
    endtask

    task automatic test_full_frame();
        dct_frame_t exp_f;
        step(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 0, 0, 1, 0);
        exp_f.count = 4'd15; exp_f.buffer = 30'h15555555;
        vectors++;
        if (frm.frame_valid !== 1'b1 || frm.frame_data !== exp_f) begin
            errors++; $display("FAIL full_frame: valid=%b data=%h want 1 %h", frm.frame_valid, frm.frame_data, exp_f);
        end
        vectors++;
        if (dct_count !== 4'd0 || dct_buffer !== 30'h0) begin
            errors++; $display("FAIL full_frame_clear: count=%0d buf=%h want 0 0", dct_count, dct_buffer);
        end
    endtask

    task automatic test_flush();
        dct_frame_t exp_f;
        step(0, 0, 0, 0, 0, 1, 1);
        step(1, 2'b10, 0, 0, 0, 1, 0);
        step(1, 2'b11, 0, 0, 0, 1, 0);
        step(1, 2'b00, 0, 0, 0, 1, 0);
        vectors++;
        if (dct_count !== 4'd3 || dct_buffer !== 30'h2c) begin
            errors++; $display("FAIL flush_accum: count=%0d buf=%h want 3 2c", dct_count, dct_buffer);
        end
        step(0, 0, 1, 0, 0, 1, 0);
        exp_f.count = 4'd3; exp_f.buffer = 30'h2c;
        vectors++;
        if (frm.frame_valid !== 1'b1 || frm.frame_data !== exp_f) begin
            errors++; $display("FAIL flush_frame: valid=%b data=%h want 1 %h", frm.frame_valid, frm.frame_data, exp_f);
        end
        step(0, 0, 1, 0, 0, 1, 0);
        vectors++;
        if (frm.frame_valid !== 1'b0) begin
            errors++; $display("FAIL flush_empty: valid=%b want 0", frm.frame_valid);
        end
    endtask

    task automatic test_backpressure();
        int         sec[$];
        bit [1:0]   c;
        dct_frame_t exp_f;
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 31; i++) begin
            c = 2'($urandom);
            if (i >= 15 && i < 30) sec.push_back(int'(c));
            step(1, c, 0, 0, 0, 0, 0);
        end
        vectors++;
        if (dct_count !== 4'd15 || overflow !== 1'b1 || frm.frame_valid !== 1'b1) begin
            errors++; $display("FAIL bp_hold: count=%0d ovf=%b valid=%b want 15 1 1", dct_count, overflow, frm.frame_valid);
        end
        vectors++;
        if (dct_buffer !== pack(sec)) begin
            errors++; $display("FAIL bp_buffer: got %h want %h", dct_buffer, pack(sec));
        end
        step(0, 0, 0, 0, 0, 1, 0);
        exp_f.count = 4'd15; exp_f.buffer = pack(sec);
        vectors++;
        if (frm.frame_valid !== 1'b1 || frm.frame_data !== exp_f || dct_count !== 4'd0) begin
            errors++; $display("FAIL bp_second: valid=%b data=%h count=%0d want 1 %h 0", frm.frame_valid, frm.frame_data, dct_count, exp_f);
        end
    endtask

    task automatic test_flush_pend();
        dct_frame_t exp_f;
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 15; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        step(1, 2'b11, 0, 0, 0, 0, 0);
        step(1, 2'b01, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0, 0, 0);
        step(1, 2'b10, 0, 0, 0, 0, 0);
        vectors++;
        if (dct_count !== 4'd2 || dct_buffer !== 30'hd || overflow !== 1'b1) begin
            errors++; $display("FAIL pend_drop: count=%0d buf=%h ovf=%b want 2 d 1", dct_count, dct_buffer, overflow);
        end
        step(0, 0, 0, 0, 1, 1, 0);
        exp_f.count = 4'd2; exp_f.buffer = 30'hd;
        vectors++;
        if (frm.frame_valid !== 1'b1 || frm.frame_data !== exp_f || overflow !== 1'b0) begin
            errors++; $display("FAIL pend_transfer: valid=%b data=%h ovf=%b want 1 %h 0", frm.frame_valid, frm.frame_data, overflow, exp_f);
        end
    endtask

    task automatic test_drain();
        int pulses = 0;
        step(0, 0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 5; i++) step(1, 2'b10, 0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0, 1, 0);
        step(1, 2'b01, 0, 0, 0, 1, 0);
        vectors++;
        if (frm.frame_valid !== 1'b1 || frm.frame_data[33:30] !== 4'd5 || overflow !== 1'b0) begin
            errors++; $display("FAIL drain_frame: valid=%b count=%0d ovf=%b want 1 5 0", frm.frame_valid, frm.frame_data[33:30], overflow);
        end
        for (int i = 0; i < 20; i++) begin
            step(1, 2'($urandom), 0, 1, 0, 1, 0);
            if (test_ending) pulses++;
        end
        vectors++;
        if (pulses !== 1 || test_has_ended !== 1'b1 || dct_count !== 4'd0 || overflow !== 1'b0) begin
            errors++; $display("FAIL drain_end: pulses=%0d ended=%b count=%0d ovf=%b want 1 1 0 0", pulses, test_has_ended, dct_count, overflow);
        end
    endtask

    task automatic test_reset_in_drain();
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 18; i++) step(1, 2'($urandom), 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        vectors++;
        if (frm.frame_valid !== 1'b1 || dct_count !== 4'd3) begin
            errors++; $display("FAIL drain_busy: valid=%b count=%0d want 1 3", frm.frame_valid, dct_count);
        end
        step(0, 0, 0, 0, 0, 0, 1);
        vectors++;
        if (dut_obs !== 72'h0) begin
            errors++; $display("FAIL drain_reset: got %h want 0", dut_obs);
        end
        step(1, 2'b11, 0, 0, 0, 0, 0);
        vectors++;
        if (dct_count !== 4'd1 || dct_buffer !== 30'h3) begin
            errors++; $display("FAIL idle_after_reset: count=%0d buf=%h want 1 3", dct_count, dct_buffer);
        end
    endtask

    task automatic test_random();
        logic [71:0] exp;
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) < 7, 2'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 6, $urandom_range(0, 99) == 0);
            exp = {pack(q), 4'(q.size()), m_hv, (m_hv ? 34'(m_hd) : 34'h0),
                   m_ovf, (m_st == 2), (m_st == 3)};
            vectors++;
            if (dut_obs !== exp) begin
                errors++; $display("FAIL random_cycle%0d: got %h want %h", i, dut_obs, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_flush();
        test_backpressure();
        test_flush_pend();
        test_drain();
        test_reset_in_drain();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
